// File: rtl/fetch.sv
// RV32I instruction fetch stage: PC generation, request/grant/response
// memory interface, in-flight PC tracking, instruction buffer, and a
// registered {pc, instr, valid} output that holds while decode stalls.
module fetch #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           ILEN       = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [ILEN-1:0]       imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  stall_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ILEN-1:0]       instr_o,
    output logic                  instr_valid_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         discard_q, discard_d;

    // PCs of requests granted but not yet answered, oldest at pcq_rd_q
    logic [ADDR_WIDTH-1:0] pcq_mem_q [FIFO_DEPTH];
    logic [PW-1:0]         pcq_wr_q, pcq_rd_q;

    // Returned instructions waiting for decode
    logic [ADDR_WIDTH-1:0] ibuf_pc_q    [FIFO_DEPTH];
    logic [ILEN-1:0]       ibuf_instr_q [FIFO_DEPTH];
    logic [PW-1:0]         ibuf_wr_q, ibuf_rd_q;
    logic [CW-1:0]         ibuf_cnt_q, ibuf_cnt_d;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ILEN-1:0]       instr_q;
    logic                  valid_q;

    logic [CW:0] credit_sum;
    logic        req;
    logic        gnt_fire;
    logic        rsp_fire;
    logic        rsp_keep;
    logic        ibuf_pop;
    logic        unused_redirect_lsb;

    // The target's low bits are forced to zero, so they are never read.
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    // Credit counts both outstanding requests and buffered instructions,
    // which guarantees every response has a free buffer slot.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, ibuf_cnt_q};
    assign req        = !rst_i && !redirect_i && (credit_sum < DEPTH_C);
    assign gnt_fire   = req && imem_gnt_i;
    assign rsp_fire   = imem_rvalid_i && (inflight_q != '0);
    assign rsp_keep   = rsp_fire && !redirect_i && (discard_q == '0);
    assign ibuf_pop   = !redirect_i && !stall_i && (ibuf_cnt_q != '0);

    assign imem_req_o    = req;
    assign imem_addr_o   = fetch_pc_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;

    // Next-state for the fetch PC, credit counters and discard count.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
        end

        inflight_d = inflight_q + CW'(gnt_fire) - CW'(rsp_fire);

        discard_d = discard_q;
        if (redirect_i) begin
            // A response arriving with the redirect is dropped directly.
            discard_d = inflight_q - CW'(rsp_fire);
        end else if (rsp_fire && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        ibuf_cnt_d = ibuf_cnt_q + CW'(rsp_keep) - CW'(ibuf_pop);
        if (redirect_i) begin
            ibuf_cnt_d = '0;
        end
    end

    // Control registers: PC, counters and queue pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            ibuf_wr_q  <= '0;
            ibuf_rd_q  <= '0;
            ibuf_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            ibuf_cnt_q <= ibuf_cnt_d;
            if (gnt_fire) begin
                pcq_wr_q <= pcq_wr_q + PW'(1);
            end
            if (rsp_fire) begin
                pcq_rd_q <= pcq_rd_q + PW'(1);
            end
            if (redirect_i) begin
                ibuf_wr_q <= '0;
                ibuf_rd_q <= '0;
            end else begin
                if (rsp_keep) begin
                    ibuf_wr_q <= ibuf_wr_q + PW'(1);
                end
                if (ibuf_pop) begin
                    ibuf_rd_q <= ibuf_rd_q + PW'(1);
                end
            end
        end
    end

    // Storage arrays; contents are only meaningful behind valid pointers.
    always_ff @(posedge clk_i) begin
        if (gnt_fire) begin
            pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
        end
        if (rsp_keep) begin
            ibuf_pc_q[ibuf_wr_q]    <= pcq_mem_q[pcq_rd_q];
            ibuf_instr_q[ibuf_wr_q] <= imem_rdata_i;
        end
    end

    // Decode-facing output register; redirect beats stall, stall holds all.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (redirect_i) begin
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            if (ibuf_cnt_q != '0) begin
                pc_q    <= ibuf_pc_q[ibuf_rd_q];
                instr_q <= ibuf_instr_q[ibuf_rd_q];
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    // A response with nothing outstanding is ignored but flagged.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(imem_rvalid_i && (inflight_q == '0)));
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios followed by random traffic, all
// checked against a queue-based model of the fetch stream.
module tb_fetch;

    localparam logic [31:0] XORV = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        instr_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_valid;

    fetch #(.ADDR_WIDTH(32), .ILEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
        .pc_o(pc_o), .instr_o(instr_o), .instr_valid_o(instr_valid)
    );

    fetch #(.ADDR_WIDTH(32), .ILEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_wrap (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(1'b1),
        .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
        .redirect_i(1'b0), .redirect_pc_i(32'h0), .stall_i(1'b0),
        .pc_o(w_pc), .instr_o(w_instr), .instr_valid_o(w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: fetch PC, outstanding requests {drop, pc},
    // buffered instructions {pc, instr}, and the output register.
    logic [31:0] m_pc;
    logic [32:0] m_out [$];
    logic [63:0] m_buf [$];
    logic        m_valid;
    logic [31:0] m_opc, m_oinstr;

    // Memory: addresses granted and not yet answered.
    logic [31:0] mem_q [$];
    logic [31:0] w_pcs [$];

    logic        last_fire, last_req;
    logic [31:0] last_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic reset_model();
        m_pc = 32'h0; m_out.delete(); m_buf.delete();
        m_valid = 1'b0; m_opc = 32'h0; m_oinstr = 32'h0;
        mem_q.delete();
        rvalid = 1'b0; rdata = 32'h0; w_rvalid = 1'b0; w_rdata = 32'h0;
    endtask

    task automatic set_in(input logic g, input logic s, input logic r,
                          input logic [31:0] t, input logic re);
        gnt = g; stall = s; redirect = r; redirect_pc = t;
        rvalid = re && (mem_q.size() > 0);
        rdata  = rvalid ? (mem_q[0] ^ XORV) : $urandom;
    endtask

    task automatic tick();
        logic        exp_req, mfire, wfire;
        logic [31:0] waddr;
        logic [32:0] o;
        logic [63:0] e;
        @(negedge clk);
        exp_req = !redirect && ((m_out.size() + m_buf.size()) < 4);
        chk("req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("addr", imem_addr, m_pc);
        last_req  = imem_req;
        last_addr = imem_addr;
        last_fire = imem_req && gnt;
        mfire     = exp_req && gnt;
        wfire     = w_req;
        waddr     = w_addr;
        @(posedge clk); #1;
        cyc++;
        if (redirect) begin
            if (rvalid && m_out.size() > 0) o = m_out.pop_front();
            foreach (m_out[i]) m_out[i][32] = 1'b1;
            m_buf.delete();
            m_valid = 1'b0;
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (!stall) begin
                if (m_buf.size() > 0) begin
                    e = m_buf.pop_front();
                    m_valid = 1'b1; m_opc = e[63:32]; m_oinstr = e[31:0];
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (rvalid && m_out.size() > 0) begin
                o = m_out.pop_front();
                if (!o[32]) m_buf.push_back({o[31:0], rdata});
            end
            if (mfire) begin
                m_out.push_back({1'b0, m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
        if (rvalid) void'(mem_q.pop_front());
        if (last_fire) mem_q.push_back(last_addr);
        chk("valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("pc", pc_o, m_opc);
        chk("instr", instr_o, m_oinstr);
        if (w_valid) w_pcs.push_back(w_pc);
        w_rvalid = wfire;
        w_rdata  = waddr ^ XORV;
    endtask

    initial begin
        int          first_fire, first_valid;
        logic [31:0] nexp;
        logic        saw_low, found;
        logic [31:0] wexp [3];
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0;

        rst = 1'b1;
        gnt = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        reset_model();
        last_fire = 1'b0; last_req = 1'b0; last_addr = 32'h0;
        #2;
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_wreq", {31'b0, w_req}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", {31'b0, instr_valid}, 32'h0);
        rst = 1'b0;

        // Streaming from reset with single-cycle memory.
        first_fire = -1; first_valid = -1; nexp = 32'h0;
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            tick();
            if (first_fire < 0 && last_fire) first_fire = cyc;
            if (first_valid < 0 && instr_valid) first_valid = cyc;
            if (first_valid >= 0) begin
                chk("stream_valid", {31'b0, instr_valid}, 32'h1);
                chk("stream_pc", pc_o, nexp);
                chk("stream_instr", instr_o, nexp ^ XORV);
                nexp = nexp + 32'd4;
            end
        end
        chk("latency", 32'(first_valid - first_fire), 32'd2);
        for (int i = 0; i < 3; i++)
            chk("wrap_pc", (i < w_pcs.size()) ? w_pcs[i] : 32'hDEAD_BEEF, wexp[i]);

        // Stall for six cycles, then resume.
        saw_low = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            tick();
            if (!last_req) saw_low = 1'b1;
        end
        chk("stall_req_drop", {31'b0, saw_low}, 32'h1);
        nexp = m_opc + 32'd4;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            tick();
            chk("resume_valid", {31'b0, instr_valid}, 32'h1);
            chk("resume_pc", pc_o, nexp);
            nexp = nexp + 32'd4;
        end

        // Redirect with requests for 0x10 and 0x14 still outstanding.
        set_in(1'b1, 1'b0, 1'b1, 32'h10, 1'b0); tick();
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);  tick();
        chk("rd_fire10", {31'b0, last_fire}, 32'h1);
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);  tick();
        chk("rd_fire14", {31'b0, last_fire}, 32'h1);
        set_in(1'b0, 1'b0, 1'b1, 32'h103, 1'b1); tick();
        chk("rd_valid_low", {31'b0, instr_valid}, 32'h0);
        found = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
        chk("rd_first_addr", last_addr, 32'h100);
        for (int i = 0; i < 20 && !found; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
            if (instr_valid) begin
                found = 1'b1;
                chk("rd_first_pc", pc_o, 32'h100);
            end
        end
        chk("rd_seen", {31'b0, found}, 32'h1);

        // Grant withheld for three cycles at 0x8.
        set_in(1'b1, 1'b0, 1'b1, 32'h8, 1'b1); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); tick();
            chk("nognt_req", {31'b0, last_req}, 32'h1);
            chk("nognt_addr", last_addr, 32'h8);
        end
        nexp = 32'h8;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
            if (instr_valid && nexp <= 32'hC) begin
                chk("nognt_pc", pc_o, nexp);
                nexp = nexp + 32'd4;
            end
        end
        chk("nognt_seen", nexp, 32'h10);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            set_in($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25,
                   $urandom_range(0, 99) < 4, t, $urandom_range(0, 99) < 70);
            tick();
        end

        // Fill two outstanding and two buffered entries, then reset mid-cycle.
        for (int i = 0; i < 20 && mem_q.size() > 0; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); tick();
        end
        set_in(1'b1, 1'b0, 1'b1, 32'h40, 1'b1); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
        end
        set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b1); tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0); tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_valid", {31'b0, instr_valid}, 32'h0);
        chk("mrst_pc", pc_o, 32'h0);
        chk("mrst_instr", instr_o, 32'h0);
        chk("mrst_req", {31'b0, imem_req}, 32'h0);
        gnt = 1'b0; stall = 1'b0; redirect = 1'b0;
        reset_model();
        @(posedge clk); #1;
        rst = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
        chk("mrst_first_addr", last_addr, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
            if (instr_valid) begin
                found = 1'b1;
                chk("mrst_first_pc", pc_o, 32'h0);
            end
        end
        chk("mrst_seen", {31'b0, found}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- RV32I instruction fetch stage; sits directly upstream of the decode stage.
- Generates the PC sequence and issues requests on a request/grant/response instruction-memory interface.
- Buffers returned instructions in a small FIFO and presents them to decode as a registered {pc, instr, valid} triple that holds on stall.
- Handles redirects from execute (taken branch, JAL, JALR) by flushing buffered instructions and discarding in-flight responses.

Parameters:
- ADDR_WIDTH, 32, PC / instruction address width.
- ILEN, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4, instruction buffer entries; also the max outstanding-plus-buffered count; power of 2, ≥2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  ADDR_WIDTH  fetch address; word aligned.
- imem_gnt_i  in  1  request accepted this cycle (req & gnt).
- imem_rvalid_i  in  1  response data valid; responses return in order.
- imem_rdata_i  in  ILEN  instruction word.
- redirect_i  in  1  control-flow redirect from execute.
- redirect_pc_i  in  ADDR_WIDTH  redirect target.
- stall_i  in  1  downstream stall; hold outputs.
- pc_o  out  ADDR_WIDTH  PC of presented instruction.
- instr_o  out  ILEN  presented instruction.
- instr_valid_o  out  1  pc_o/instr_o valid.

Behaviour:
- Reset (async, takes effect immediately):
  - fetch_pc = RESET_PC; inflight = 0; discard_cnt = 0; FIFO empty.
  - pc_o = 0, instr_o = 0, instr_valid_o = 0; imem_req_o = 0 while rst_i is high.
- Issue:
  - imem_req_o = !redirect_i && (inflight + fifo_count < FIFO_DEPTH); imem_addr_o = fetch_pc.
  - On req & gnt: fetch_pc += 4, wrapping modulo 2^ADDR_WIDTH (0xFFFFFFFC → 0x0).
  - The PC is pushed into the in-flight PC queue (FIFO_DEPTH entries).
  - Without gnt, req and addr hold stable. Exception: a redirect may drop req for one cycle; memory samples req per cycle.
- inflight counter: +1 on gnt, -1 on rvalid; both in the same cycle leaves it unchanged. Never exceeds FIFO_DEPTH.
- Response, when discard_cnt == 0:
  - {queued pc, imem_rdata_i} is written to the instruction FIFO; the queued pc is popped.
  - Space is guaranteed by the issue credit.
- Response, when discard_cnt > 0: data is dropped, the queued pc is popped, and discard_cnt decrements.
- rvalid with inflight == 0 is a protocol violation: ignored, with a simulation assertion.
- Output register, on each rising edge:
  - Redirect has priority: instr_valid_o <= 0.
  - Else if !stall_i and FIFO non-empty: pop the head into pc_o/instr_o and set instr_valid_o <= 1.
  - Else if !stall_i and FIFO empty: instr_valid_o <= 0, with pc_o/instr_o holding.
  - Else (stall_i) all three hold.
- Latency: first-instruction latency is 3 cycles from gnt with 1-cycle memory: gnt in C0, rvalid in C1, FIFO write at end of C1, output load at end of C2, valid visible in C3.
- Throughput: 1 instr/cycle sustained with 1-cycle memory and FIFO_DEPTH = 4.
- Redirect (single-cycle pulse, wins over stall_i and over a same-cycle response):
  - fetch_pc <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}.
  - FIFO flushed; instr_valid_o <= 0.
  - discard_cnt <= inflight minus any response arriving this cycle; that response is itself discarded.
  - No gnt is possible in the redirect cycle, because req is low.
  - Next cycle: request at the target address.
- Redirect while discard_cnt > 0: discard_cnt is recomputed from the current inflight, the same as above.
- A redirect asserted back-to-back on consecutive cycles is legal. The last target wins.
- FIFO full or credit exhausted: req low until a pop or response frees credit. No instruction is lost or duplicated.

Test Plan:
- RESET_PC=0, gnt always 1, rvalid 1 cycle after gnt, rdata=addr^0xA5A5A5A5, stall_i=0 → instr_valid_o rises 3 cycles after first gnt. pc_o then reads 0x0, 0x4, 0x8… on consecutive cycles, with matching instr_o and no bubbles.
- Steady stream, stall_i high 6 cycles →
  - pc_o/instr_o hold.
  - req drops once inflight + fifo_count = 4.
  - After release, pcs continue strictly +4 with no gap or duplicate.
- Two requests in flight (pcs 0x10, 0x14), redirect_i with redirect_pc_i=0x103 →
  - instr_valid_o = 0 next cycle.
  - Responses for 0x10 and 0x14 are dropped.
  - Next request address is 0x100; the first valid pc_o is 0x100.
- imem_gnt_i low 3 cycles while req asserted at 0x8 → imem_addr_o stable at 0x8 throughout, then 0x8, 0xC fetched in order.
- RESET_PC=0xFFFFFFF8 → pc_o sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rst_i asserted mid-cycle with 2 requests in flight and FIFO holding 2 entries →
  - Outputs zero and req low immediately, without waiting for a clock edge.
  - After release, first imem_addr_o = RESET_PC and the first valid pc_o = RESET_PC.
